// File: rtl/key_event_pkg.sv
// Shared types and helpers for the push-button event front-end.
//   key_state_e : per-channel debounce/hold state
//   cnt_w()     : counter width for a terminal count, never less than 1 bit
package key_event_pkg;

    typedef enum logic [1:0] {
        KS_IDLE       = 2'd0,
        KS_PRESS_WAIT = 2'd1,
        KS_HELD       = 2'd2,
        KS_REL_WAIT   = 2'd3
    } key_state_e;

    localparam int unsigned DEF_NUM_KEYS     = 3;
    localparam int unsigned DEF_DEBOUNCE_CYC = 250000;
    localparam int unsigned DEF_LONG_CYC     = 50000000;

    // Width able to hold 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: 2-FF synchroniser, polarity normalisation, debounce FSM
// and long-press hold counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   key         : raw asynchronous key input
//   level       : debounced level, 1 = pressed
//   press_pulse : 1-cycle pulse on accepted press
//   long_pulse  : 1-cycle pulse when cumulative hold reaches LONG_CYC
//   rel_pulse   : 1-cycle pulse on accepted release
module key_event_ch
    import key_event_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press_pulse,
    output logic long_pulse,
    output logic rel_pulse
);

    localparam int unsigned DB_W   = cnt_w(DEBOUNCE_CYC);
    localparam int unsigned HOLD_W = cnt_w(LONG_CYC);
    localparam logic        REL_VAL = (ACTIVE_LOW != 0);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    logic              sync1;
    logic              sync2;
    logic              p;
    key_state_e        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fired;

    // Raw -> sync2 is two cycles; p is 1 when the key is pressed.
    assign p = sync2 ^ REL_VAL;

    // Synchroniser, FSM and counters; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= REL_VAL;
            sync2       <= REL_VAL;
            state       <= KS_IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_fired  <= 1'b0;
            level       <= 1'b0;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            rel_pulse   <= 1'b0;
        end else begin
            sync1       <= key;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            rel_pulse   <= 1'b0;
            case (state)
                KS_IDLE: begin
                    if (p) begin
                        state  <= KS_PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                KS_PRESS_WAIT: begin
                    if (!p) begin
                        state <= KS_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= KS_HELD;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                KS_HELD: begin
                    if (!p) begin
                        // hold_cnt is frozen while a release is being qualified
                        state  <= KS_REL_WAIT;
                        db_cnt <= '0;
                    end else if (!long_fired) begin
                        if (hold_cnt == HOLD_LAST) begin
                            long_pulse <= 1'b1;
                            long_fired <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                KS_REL_WAIT: begin
                    if (p) begin
                        state  <= KS_HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state      <= KS_IDLE;
                        level      <= 1'b0;
                        rel_pulse  <= 1'b1;
                        hold_cnt   <= '0;
                        long_fired <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= KS_IDLE;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Push-button front-end: NUM_KEYS independent debounced channels producing
// press / long-press / release pulses and a stable level per key.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : 0 masks all event pulses (channels keep running)
//   i_key          : raw asynchronous keys
//   o_level        : debounced level per key, 1 = pressed (never masked)
//   o_press        : press pulses
//   o_long         : long-press pulses (once per press)
//   o_release      : release pulses
//   o_any_press    : OR of o_press
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = DEF_NUM_KEYS,
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [NUM_KEYS-1:0] i_key,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_long,
    output logic [NUM_KEYS-1:0] o_release,
    output logic                o_any_press
);

    logic [NUM_KEYS-1:0] ch_press;
    logic [NUM_KEYS-1:0] ch_long;
    logic [NUM_KEYS-1:0] ch_rel;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_event_ch #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC)
        ) u_ch (
            .clk        (i_clk),
            .rst_n      (i_rst_n),
            .key        (i_key[k]),
            .level      (o_level[k]),
            .press_pulse(ch_press[k]),
            .long_pulse (ch_long[k]),
            .rel_pulse  (ch_rel[k])
        );
    end

    // Masking is per cycle: an event generated while i_en is low is dropped.
    assign o_press     = ch_press & {NUM_KEYS{i_en}};
    assign o_long      = ch_long  & {NUM_KEYS{i_en}};
    assign o_release   = ch_rel   & {NUM_KEYS{i_en}};
    assign o_any_press = |o_press;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with DEBOUNCE_CYC=4, LONG_CYC=16.
// Inputs change 1 time unit after a rising edge; "i" counts rising edges
// since the stimulus change, and outputs are sampled 1 unit after each edge.
module tb_key_event_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] key;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] long_o;
    logic [2:0] rel;
    logic       any;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key_event_gen #(
        .NUM_KEYS    (3),
        .ACTIVE_LOW  (1),
        .DEBOUNCE_CYC(4),
        .LONG_CYC    (16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_key      (key),
        .o_level    (level),
        .o_press    (press),
        .o_long     (long_o),
        .o_release  (rel),
        .o_any_press(any)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        key   = 3'b111;
        repeat (3) step();
        total++;
        if ({level, press, long_o, rel, any} !== 13'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {level, press, long_o, rel, any}, 13'b0);
        end
        rst_n = 1'b1;
        repeat (3) step();
        total++;
        if ({level, press, long_o, rel, any} !== 13'b0) begin
            bad++;
            $display("FAIL post_reset_idle got=%b exp=%b", {level, press, long_o, rel, any}, 13'b0);
        end
    endtask

    // key0 pressed; edges 1..10, press expected after edge 7
    task automatic test_clean_press();
        logic [2:0] ep;
        logic [2:0] el;
        key[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            ep = (i == 7) ? 3'b001 : 3'b000;
            el = (i >= 7) ? 3'b001 : 3'b000;
            total++;
            if (press !== ep) begin bad++; $display("FAIL clean_press i=%0d got=%b exp=%b", i, press, ep); end
            total++;
            if (level !== el) begin bad++; $display("FAIL clean_level i=%0d got=%b exp=%b", i, level, el); end
            total++;
            if (any !== (i == 7)) begin bad++; $display("FAIL clean_any i=%0d got=%b exp=%b", i, any, (i == 7)); end
            total++;
            if ((long_o | rel) !== 3'b000) begin bad++; $display("FAIL clean_other i=%0d got=%b exp=000", i, long_o | rel); end
        end
    endtask

    // continues from test_clean_press: long after edge 23, release 7 edges after raw rise
    task automatic test_long_press();
        logic [2:0] e;
        for (int i = 11; i <= 37; i++) begin
            step();
            e = (i == 23) ? 3'b001 : 3'b000;
            total++;
            if (long_o !== e) begin bad++; $display("FAIL long_pulse i=%0d got=%b exp=%b", i, long_o, e); end
            total++;
            if ((press | rel) !== 3'b000 || level !== 3'b001) begin
                bad++;
                $display("FAIL long_hold i=%0d got=%b/%b/%b exp=000/000/001", i, press, rel, level);
            end
        end
        key[0] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            e = (j == 7) ? 3'b001 : 3'b000;
            total++;
            if (rel !== e) begin bad++; $display("FAIL release_pulse j=%0d got=%b exp=%b", j, rel, e); end
            e = (j < 7) ? 3'b001 : 3'b000;
            total++;
            if (level !== e) begin bad++; $display("FAIL release_level j=%0d got=%b exp=%b", j, level, e); end
            total++;
            if ((long_o | press) !== 3'b000) begin bad++; $display("FAIL release_other j=%0d got=%b exp=000", j, long_o | press); end
        end
    endtask

    // key1 low 3, high 1, low 2, then high: never debounced
    task automatic test_bounce();
        key[1] = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 3) key[1] = 1'b1;
            if (i == 4) key[1] = 1'b0;
            if (i == 6) key[1] = 1'b1;
            total++;
            if ({press[1], level[1], rel[1], long_o[1]} !== 4'b0) begin
                bad++;
                $display("FAIL bounce i=%0d got=%b exp=0000", i, {press[1], level[1], rel[1], long_o[1]});
            end
        end
    endtask

    // key2 held; raw glitch high after edges 10..11; hold_cnt frozen 3 cycles so long moves 23 -> 26
    task automatic test_release_glitch();
        logic [2:0] e;
        key[2] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 10) key[2] = 1'b1;
            if (i == 12) key[2] = 1'b0;
            e = (i == 7) ? 3'b100 : 3'b000;
            total++;
            if (press !== e) begin bad++; $display("FAIL glitch_press i=%0d got=%b exp=%b", i, press, e); end
            e = (i == 26) ? 3'b100 : 3'b000;
            total++;
            if (long_o !== e) begin bad++; $display("FAIL glitch_long i=%0d got=%b exp=%b", i, long_o, e); end
            total++;
            if (rel !== 3'b000) begin bad++; $display("FAIL glitch_release i=%0d got=%b exp=000", i, rel); end
            e = (i >= 7) ? 3'b100 : 3'b000;
            total++;
            if (level !== e) begin bad++; $display("FAIL glitch_level i=%0d got=%b exp=%b", i, level, e); end
        end
        key[2] = 1'b1;
        repeat (10) step();
    endtask

    // key0 + key2 together, then again with events masked
    task automatic test_simultaneous_mask();
        logic [2:0] e;
        key = 3'b010;
        for (int i = 1; i <= 10; i++) begin
            step();
            e = (i == 7) ? 3'b101 : 3'b000;
            total++;
            if (press !== e) begin bad++; $display("FAIL simul_press i=%0d got=%b exp=%b", i, press, e); end
            total++;
            if (any !== (i == 7)) begin bad++; $display("FAIL simul_any i=%0d got=%b exp=%b", i, any, (i == 7)); end
        end
        key = 3'b111;
        repeat (10) step();
        total++;
        if (level !== 3'b000) begin bad++; $display("FAIL simul_released got=%b exp=000", level); end
        en  = 1'b0;
        key = 3'b010;
        for (int i = 1; i <= 10; i++) begin
            step();
            e = (i >= 7) ? 3'b101 : 3'b000;
            total++;
            if (press !== 3'b000 || any !== 1'b0) begin
                bad++;
                $display("FAIL mask_press i=%0d got=%b/%b exp=000/0", i, press, any);
            end
            total++;
            if (level !== e) begin bad++; $display("FAIL mask_level i=%0d got=%b exp=%b", i, level, e); end
        end
        key = 3'b111;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if (rel !== 3'b000) begin bad++; $display("FAIL mask_release i=%0d got=%b exp=000", i, rel); end
        end
        en = 1'b1;
    endtask

    // reset for 2 edges while key1 held; fresh press 7 edges after deassertion
    task automatic test_reset_mid_hold();
        logic [2:0] e;
        key = 3'b101;
        repeat (10) step();
        total++;
        if (level !== 3'b010) begin bad++; $display("FAIL rst_pre_level got=%b exp=010", level); end
        rst_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 2) rst_n = 1'b1;
            if (i == 1) begin
                total++;
                if ({level, press, long_o, rel, any} !== 13'b0) begin
                    bad++;
                    $display("FAIL rst_outputs got=%b exp=%b", {level, press, long_o, rel, any}, 13'b0);
                end
            end
            total++;
            if (rel !== 3'b000) begin bad++; $display("FAIL rst_release i=%0d got=%b exp=000", i, rel); end
            e = (i == 9) ? 3'b010 : 3'b000;
            total++;
            if (press !== e) begin bad++; $display("FAIL rst_press i=%0d got=%b exp=%b", i, press, e); end
            e = (i >= 9) ? 3'b010 : 3'b000;
            total++;
            if (level !== e) begin bad++; $display("FAIL rst_level i=%0d got=%b exp=%b", i, level, e); end
        end
        key = 3'b111;
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_long_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous_mask();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
